muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative RISC-V M-extension unit.
//   DATA_W / ITER : operand width and step count (32 only)
//   CNT_W         : step counter width
//   op_e          : funct3 operation encoding
//   state_e       : control FSM states
package muldiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER   = 32;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the RISC-V M extension.
// One shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle
// over operand magnitudes, sign fixed up on the final step.
//   clk, reset     : clock, synchronous active-high reset
//   start, funct3  : op request (sampled only in IDLE) and op select
//   op_a, op_b     : rs1 / rs2 values, latched on acceptance
//   flush          : abort any op, no done pulse, result untouched
//   busy           : high while iterating
//   done           : one-cycle pulse when result is updated
//   result         : registered result, held between ops
module muldiv_unit #(
    parameter int unsigned DATA_W = muldiv_pkg::DATA_W,
    parameter int unsigned ITER   = muldiv_pkg::ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    import muldiv_pkg::CNT_W;
    import muldiv_pkg::op_e;
    import muldiv_pkg::OP_MUL;
    import muldiv_pkg::OP_MULH;
    import muldiv_pkg::OP_MULHSU;
    import muldiv_pkg::OP_MULHU;
    import muldiv_pkg::OP_DIV;
    import muldiv_pkg::OP_DIVU;
    import muldiv_pkg::OP_REM;
    import muldiv_pkg::OP_REMU;
    import muldiv_pkg::state_e;
    import muldiv_pkg::ST_IDLE;
    import muldiv_pkg::ST_CALC;
    import muldiv_pkg::ST_DONE;

    localparam int unsigned ACC_W = 2 * DATA_W;

    // Magnitude of x when it is treated as signed for this op.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
        return (sgn && x[DATA_W-1]) ? -x : x;
    endfunction

    // Re-apply the result sign after magnitude arithmetic.
    function automatic logic [ACC_W-1:0] fix64(input logic [ACC_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [DATA_W-1:0] fix32(input logic [DATA_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic              last_step;

    op_e               op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              neg_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] result_q;

    // Operand decode at acceptance: signedness, magnitudes, special cases.
    logic              in_div, in_rem, a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic              div_zero, div_ovf, special;
    logic [DATA_W-1:0] a_mag, b_mag, special_res;

    always_comb begin
        in_div      = funct3[2];
        in_rem      = funct3[2] & funct3[1];
        a_sgn       = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV)  || (funct3 == OP_REM);
        b_sgn       = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
        a_neg       = a_sgn & op_a[DATA_W-1];
        b_neg       = b_sgn & op_b[DATA_W-1];
        a_mag       = mag(op_a, a_sgn);
        b_mag       = mag(op_b, b_sgn);
        // Remainder takes the dividend's sign; everything else the xor.
        neg_in      = in_rem ? a_neg : (a_neg ^ b_neg);
        div_zero    = in_div && (op_b == '0);
        div_ovf     = in_div && !funct3[0] &&
                      (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
        special     = div_zero || div_ovf;
        special_res = in_rem ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
    end

    // One iteration step plus the signed final result taken from it.
    logic [DATA_W:0]   mul_sum, div_diff;
    logic [ACC_W-1:0]  acc_step, prod_fix;
    logic [DATA_W-1:0] q_fix, r_fix, final_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        div_diff = acc_q[ACC_W-1:DATA_W-1] - {1'b0, b_q};
        if (op_q[2]) begin
            // Borrow means the shifted remainder is below the divisor: restore.
            acc_step = div_diff[DATA_W] ? {acc_q[ACC_W-2:0], 1'b0}
                                        : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[DATA_W-1:1]};
        end
        prod_fix = fix64(acc_step, neg_q);
        q_fix    = fix32(acc_step[DATA_W-1:0], neg_q);
        r_fix    = fix32(acc_step[ACC_W-1:DATA_W], neg_q);
        case (op_q)
            OP_MUL:                       final_res = prod_fix[DATA_W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[ACC_W-1:DATA_W];
            OP_DIV, OP_DIVU:              final_res = q_fix;
            OP_REM, OP_REMU:              final_res = r_fix;
            default:                      final_res = q_fix;
        endcase
    end

    assign last_step = (cnt_q == CNT_W'(ITER - 1));

    // Control FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Control FSM: next state and registered-output next values.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    accept  = 1'b1;
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // Datapath: operand latch, iteration and result update.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(funct3);
            a_q   <= a_mag;
            b_q   <= b_mag;
            neg_q <= neg_in;
            cnt_q <= '0;
            // Low half holds the multiplier or the dividend being consumed.
            acc_q <= {{DATA_W{1'b0}}, (in_div ? a_mag : b_mag)};
            if (special) begin
                result_q <= special_res;
            end
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            acc_q <= acc_step;
            if (last_step) begin
                result_q <= final_res;
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("result", result, exp_q.pop_front());
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Issue one op, scramble the operand inputs, then wait for done with a bound.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int          lat;
        int          bcnt;
        logic [31:0] e;
        bit          spc;
        e   = ref_model(f, a, b);
        spc = is_special(f, a, b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(e);
        last_res = e;
        @(negedge clk);
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        lat  = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), spc ? 32'd1 : 32'd33);
        check({tag, " busy_cycles"}, 32'(bcnt), spc ? 32'd0 : 32'd32);
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return $urandom_range(0, 20);
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        last_res = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "MUL 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
        run_op(3'd5, 32'd100, 32'd7, "DIVU 100/7");
        run_op(3'd7, 32'd100, 32'd7, "REMU 100/7");
        run_op(3'd5, 32'd5, 32'd0, "DIVU 5/0");
        run_op(3'd6, 32'd5, 32'd0, "REM 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM ovf");

        // Flush mid-calculation, with a stray start while busy.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, last_res);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("flush no_done", 32'(dones), 32'd0);

        // Reset mid-calculation.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midreset no_done", 32'(dones), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, "MUL 3*4");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = pick($urandom_range(0, 9));
            b = pick($urandom_range(0, 9));
            run_op(f, a, b, $sformatf("rnd%0d f%0d", i, f));
        end

        repeat (3) @(negedge clk);
        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
